// File: rtl/pico_cpu_mc.sv
// Multicycle picoMIPS core: FETCH/EXEC with branches, a 3-operand GPR file, a switch-handshake stall and HALT.
// Optional signed fractional multiplier is built only when PICO_CPU_MULT_EN is defined.
module pico_cpu_mc #(
    parameter int N         = 8,
    parameter int O_SIZE    = 6,
    parameter int P_SIZE    = 5,
    parameter int R_SIZE    = 3,
    parameter int SW_WIDTH  = 10,
    parameter int SW_HS_BIT = 8,
    parameter int I_SIZE    = O_SIZE + 2*R_SIZE + N
) (
    input  logic                clk,
    input  logic                rst,
    output logic [P_SIZE-1:0]   imem_addr,
    input  logic [I_SIZE-1:0]   imem_data,
    input  logic [SW_WIDTH-1:0] switchesIn,
    output logic [N-1:0]        displayResult,
    output logic [P_SIZE-1:0]   displayPC,
    output logic                halted,
    output logic                waiting
);

    localparam int unsigned NREG = 2**R_SIZE;

    localparam logic [O_SIZE-1:0] OP_ADD    = O_SIZE'(6'h01);
    localparam logic [O_SIZE-1:0] OP_ADDI   = O_SIZE'(6'h02);
    localparam logic [O_SIZE-1:0] OP_SUB    = O_SIZE'(6'h03);
    localparam logic [O_SIZE-1:0] OP_SUBI   = O_SIZE'(6'h04);
    localparam logic [O_SIZE-1:0] OP_MUL    = O_SIZE'(6'h05);
    localparam logic [O_SIZE-1:0] OP_MULI   = O_SIZE'(6'h06);
    localparam logic [O_SIZE-1:0] OP_LDSW   = O_SIZE'(6'h07);
    localparam logic [O_SIZE-1:0] OP_OUT    = O_SIZE'(6'h08);
    localparam logic [O_SIZE-1:0] OP_BEQ    = O_SIZE'(6'h09);
    localparam logic [O_SIZE-1:0] OP_JMP    = O_SIZE'(6'h0A);
    localparam logic [O_SIZE-1:0] OP_WAITSW = O_SIZE'(6'h0B);
    localparam logic [O_SIZE-1:0] OP_HALT   = O_SIZE'(6'h3F);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

    state_t              r_state, w_state_nxt;
    logic [P_SIZE-1:0]   r_pc, w_pc_nxt, w_pc_inc, w_target;
    logic [N-1:0]        r_gpr [NREG];
    logic [N-1:0]        r_disp, w_disp_nxt;
    logic                r_hs_want, w_hs_want_nxt;
    logic                w_we;
    logic [N-1:0]        w_wdata;

    logic [O_SIZE-1:0]   w_op;
    logic [R_SIZE-1:0]   w_rd, w_rs;
    logic [N-1:0]        w_imm, w_rd_val, w_rs_val, w_sw_val;
    logic                w_unused_sig;

    assign w_op     = imem_data[I_SIZE-1 -: O_SIZE];
    assign w_rd     = imem_data[N+R_SIZE +: R_SIZE];
    assign w_rs     = imem_data[N +: R_SIZE];
    assign w_imm    = imem_data[N-1:0];
    assign w_rd_val = (w_rd == '0) ? '0 : r_gpr[w_rd];
    assign w_rs_val = (w_rs == '0) ? '0 : r_gpr[w_rs];
    assign w_pc_inc = r_pc + P_SIZE'(1);
    assign w_target = w_imm[P_SIZE-1:0];

    generate
        if (SW_WIDTH >= N) begin : g_sw_trunc
            assign w_sw_val = switchesIn[N-1:0];
        end else begin : g_sw_zext
            assign w_sw_val = {{(N-SW_WIDTH){1'b0}}, switchesIn};
        end
    endgenerate

`ifdef PICO_CPU_MULT_EN
    // Q1.(N-1) product: drop the redundant sign bit and the low N-1 fraction bits.
    logic [N-1:0]   w_mul_b;
    logic [2*N-1:0] w_prod;
    assign w_mul_b = (w_op == OP_MULI) ? w_imm : w_rs_val;
    assign w_prod  = {{N{w_rd_val[N-1]}}, w_rd_val} * {{N{w_mul_b[N-1]}}, w_mul_b};
    assign w_unused_sig = &{1'b0, switchesIn, w_prod[2*N-1], w_prod[N-2:0]};
`else
    assign w_unused_sig = &{1'b0, switchesIn};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_disp_nxt    = r_disp;
        w_hs_want_nxt = r_hs_want;
        w_we          = 1'b0;
        w_wdata       = w_rd_val;
        case (r_state)
            S_FETCH: w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_pc_inc;
                case (w_op)
                    OP_ADD:  begin w_we = 1'b1; w_wdata = w_rd_val + w_rs_val; end
                    OP_ADDI: begin w_we = 1'b1; w_wdata = w_rd_val + w_imm;    end
                    OP_SUB:  begin w_we = 1'b1; w_wdata = w_rd_val - w_rs_val; end
                    OP_SUBI: begin w_we = 1'b1; w_wdata = w_rd_val - w_imm;    end
`ifdef PICO_CPU_MULT_EN
                    OP_MUL, OP_MULI: begin w_we = 1'b1; w_wdata = w_prod[2*N-2:N-1]; end
`endif
                    OP_LDSW: begin w_we = 1'b1; w_wdata = w_sw_val; end
                    OP_OUT:  w_disp_nxt = w_rd_val;
                    OP_BEQ:  if (w_rd_val == w_rs_val) w_pc_nxt = w_target;
                    OP_JMP:  w_pc_nxt = w_target;
                    OP_WAITSW: begin
                        // Latch the wanted level so WAIT does not depend on the ROM output.
                        if (switchesIn[SW_HS_BIT] != w_imm[0]) begin
                            w_state_nxt   = S_WAIT;
                            w_pc_nxt      = r_pc;
                            w_hs_want_nxt = w_imm[0];
                        end
                    end
                    OP_HALT: begin w_state_nxt = S_HALT; w_pc_nxt = r_pc; end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (switchesIn[SW_HS_BIT] == r_hs_want) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_disp    <= '0;
            r_hs_want <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) r_gpr[i[R_SIZE-1:0]] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_disp    <= w_disp_nxt;
            r_hs_want <= w_hs_want_nxt;
            if (w_we && (w_rd != '0)) r_gpr[w_rd] <= w_wdata;
        end
    end

    assign imem_addr     = r_pc;
    assign displayPC     = r_pc;
    assign displayResult = r_disp;
    assign halted        = (r_state == S_HALT);
    assign waiting       = (r_state == S_WAIT);

endmodule

// File: tb/tb_pico_cpu_mc.sv
// Directed bench for pico_cpu_mc: per-test ROM images, hand-computed expectations.
// Expectations for MUL/MULI follow PICO_CPU_MULT_EN.
module tb_pico_cpu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  imem_addr;
    logic [19:0] imem_data;
    logic [9:0]  switchesIn = '0;
    logic [7:0]  displayResult;
    logic [4:0]  displayPC;
    logic        halted;
    logic        waiting;

    logic [19:0] rom [32];
    int n_checks = 0;
    int n_fail   = 0;

    pico_cpu_mc #(.N(8), .O_SIZE(6), .P_SIZE(5), .R_SIZE(3), .SW_WIDTH(10), .SW_HS_BIT(8)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .switchesIn(switchesIn), .displayResult(displayResult), .displayPC(displayPC),
        .halted(halted), .waiting(waiting)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= rom[imem_addr];

    function automatic logic [19:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 32; i++) rom[i] = enc(6'h3F, 3'd0, 3'd0, 8'd0);
    endtask

    task automatic start;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // Test 1a: GPRs cleared by reset
        clear_rom;
        rom[0] = enc(6'h02, 3'd1, 3'd0, 8'd5);
        rom[1] = enc(6'h08, 3'd1, 3'd0, 8'd0);
        start;
        step(4);
        check("t1_pre_disp", displayResult, 8'd5);
        rst = 1'b1;
        step(3);
        check("t1_rst_pc", displayPC, 5'd0);
        check("t1_rst_disp", displayResult, 8'd0);
        check("t1_rst_halt", halted, 1'b0);
        check("t1_rst_wait", waiting, 1'b0);
        rom[0] = enc(6'h08, 3'd1, 3'd0, 8'd0);
        rom[1] = enc(6'h3F, 3'd0, 3'd0, 8'd0);
        rst = 1'b0;
        step(2);
        check("t1_r1_cleared", displayResult, 8'd0);

        // Test 1b: reset during EXEC of ADDI discards the write
        rom[0] = enc(6'h02, 3'd1, 3'd0, 8'd5);
        rom[1] = enc(6'h08, 3'd1, 3'd0, 8'd0);
        start;
        step(1);
        rst = 1'b1;
        step(3);
        check("t1b_pc", displayPC, 5'd0);
        check("t1b_addr", imem_addr, 5'd0);
        rom[0] = enc(6'h08, 3'd1, 3'd0, 8'd0);
        rom[1] = enc(6'h3F, 3'd0, 3'd0, 8'd0);
        rst = 1'b0;
        step(2);
        check("t1b_abort", displayResult, 8'd0);

        // Test 2: ADDI wrap
        clear_rom;
        rom[0] = enc(6'h02, 3'd1, 3'd0, 8'd200);
        rom[1] = enc(6'h02, 3'd1, 3'd0, 8'd100);
        rom[2] = enc(6'h08, 3'd1, 3'd0, 8'd0);
        start;
        step(5);
        check("t2_early", displayResult, 8'd0);
        step(1);
        check("t2_wrap", displayResult, 8'd44);
        step(2);
        check("t2_halt", halted, 1'b1);
        check("t2_halt_pc", displayPC, 5'd3);

        // Test 3: r0, BEQ taken/not taken, SUB/SUBI/ADD
        clear_rom;
        rom[0]  = enc(6'h02, 3'd1, 3'd0, 8'd9);
        rom[1]  = enc(6'h08, 3'd1, 3'd0, 8'd0);
        rom[2]  = enc(6'h02, 3'd0, 3'd0, 8'd7);
        rom[3]  = enc(6'h08, 3'd0, 3'd0, 8'd0);
        rom[4]  = enc(6'h02, 3'd2, 3'd0, 8'd3);
        rom[5]  = enc(6'h02, 3'd3, 3'd0, 8'd3);
        rom[6]  = enc(6'h09, 3'd2, 3'd3, 8'd12);
        rom[12] = enc(6'h09, 3'd2, 3'd0, 8'd20);
        rom[13] = enc(6'h03, 3'd2, 3'd1, 8'd0);
        rom[14] = enc(6'h04, 3'd2, 3'd0, 8'd2);
        rom[15] = enc(6'h08, 3'd2, 3'd0, 8'd0);
        rom[16] = enc(6'h01, 3'd2, 3'd3, 8'd0);
        rom[17] = enc(6'h08, 3'd2, 3'd0, 8'd0);
        start;
        step(4);
        check("t3_out9", displayResult, 8'd9);
        step(4);
        check("t3_r0", displayResult, 8'd0);
        step(6);
        check("t3_beq_taken", displayPC, 5'd12);
        step(2);
        check("t3_beq_not", displayPC, 5'd13);
        step(6);
        check("t3_sub", displayResult, 8'd248);
        step(4);
        check("t3_add", displayResult, 8'd251);

        // Test 4: WAITSW stall, release, LDSW, no-stall case
        clear_rom;
        switchesIn = 10'h000;
        rom[0] = enc(6'h0B, 3'd0, 3'd0, 8'd1);
        rom[1] = enc(6'h07, 3'd1, 3'd0, 8'd0);
        rom[2] = enc(6'h08, 3'd1, 3'd0, 8'd0);
        rom[3] = enc(6'h0B, 3'd0, 3'd0, 8'd1);
        start;
        step(2);
        check("t4_wait", waiting, 1'b1);
        check("t4_wait_pc", displayPC, 5'd0);
        step(10);
        check("t4_wait10", waiting, 1'b1);
        check("t4_wait10_pc", displayPC, 5'd0);
        switchesIn = 10'h1A5;
        step(1);
        check("t4_rel_wait", waiting, 1'b0);
        check("t4_rel_pc", displayPC, 5'd1);
        step(4);
        check("t4_ldsw", displayResult, 8'hA5);
        step(2);
        check("t4_nostall_pc", displayPC, 5'd4);
        check("t4_nostall_wait", waiting, 1'b0);

        // Test 5: jump to 31, wrap to 0, HALT freeze
        clear_rom;
        switchesIn = 10'h000;
        rom[0]  = enc(6'h09, 3'd1, 3'd0, 8'd30);
        rom[1]  = enc(6'h08, 3'd1, 3'd0, 8'd0);
        rom[30] = enc(6'h0A, 3'd0, 3'd0, 8'd31);
        rom[31] = enc(6'h02, 3'd1, 3'd0, 8'd1);
        start;
        step(2);
        check("t5_pc30", displayPC, 5'd30);
        step(2);
        check("t5_pc31", displayPC, 5'd31);
        step(2);
        check("t5_wrap", displayPC, 5'd0);
        step(4);
        check("t5_out", displayResult, 8'd1);
        step(2);
        check("t5_halted", halted, 1'b1);
        check("t5_halt_pc", displayPC, 5'd2);
        step(20);
        check("t5_frozen_pc", displayPC, 5'd2);
        check("t5_frozen_halt", halted, 1'b1);
        check("t5_frozen_disp", displayResult, 8'd1);

        // Test 6: MUL / MULI
        clear_rom;
        rom[0] = enc(6'h02, 3'd1, 3'd0, 8'h40);
        rom[1] = enc(6'h02, 3'd2, 3'd0, 8'h40);
        rom[2] = enc(6'h05, 3'd1, 3'd2, 8'h00);
        rom[3] = enc(6'h08, 3'd1, 3'd0, 8'h00);
        rom[4] = enc(6'h02, 3'd3, 3'd0, 8'hC0);
        rom[5] = enc(6'h06, 3'd3, 3'd0, 8'h40);
        rom[6] = enc(6'h08, 3'd3, 3'd0, 8'h00);
        start;
        step(8);
`ifdef PICO_CPU_MULT_EN
        check("t6_mul", displayResult, 8'h20);
`else
        check("t6_mul", displayResult, 8'h40);
`endif
        step(6);
`ifdef PICO_CPU_MULT_EN
        check("t6_muli", displayResult, 8'hE0);
`else
        check("t6_muli", displayResult, 8'hC0);
`endif
        check("t6_pc", displayPC, 5'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
